// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared SD SPI state encodings and default link constants.
package sd_spi_pkg;
  typedef enum logic [1:0] {IDLE, HUNT, SYNC, RECEIVE} state_t;
  localparam int SD_R1_BITS = 8;
  localparam int SD_NCR_BITS = 64;
  localparam logic [7:0] SD_TOKEN_START = 8'hFE;
endpackage

// File: rtl/spi_receiver_if.sv
// spi_receiver_if: strobe, control and result bundle for the SPI deserializer.
interface spi_receiver_if #(parameter int DATA_BITS = 8);
  logic sclk_posedge;
  logic sclk_negedge;
  logic en;
  logic wait_start;
  logic in;
  logic [DATA_BITS-1:0] data;
  logic done;
  logic timeout;
  modport master (output sclk_posedge, sclk_negedge, en, wait_start, in, input data, done, timeout);
  modport slave (input sclk_posedge, sclk_negedge, en, wait_start, in, output data, done, timeout);
endinterface

// File: rtl/spi_receiver.sv
// spi_receiver: MISO deserializer with start-bit hunt (timeout) or byte-aligned capture.
module spi_receiver
  import sd_spi_pkg::*;
#(
  parameter int DATA_BITS = SD_R1_BITS,
  parameter int TIMEOUT_BITS = SD_NCR_BITS
) (
  input logic clk,
  input logic reset,
  spi_receiver_if.slave bus
);
  localparam int HW = $clog2(TIMEOUT_BITS);
  localparam int RW = $clog2(DATA_BITS + 1);
  state_t state;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_next;
  logic [HW-1:0] hunt;
  logic [RW-1:0] remaining;
  logic [2:0] bit_counter;
  assign shift_next = {shift[DATA_BITS-2:0], bus.in};
  assign bus.done = state == IDLE && !bus.en;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.data <= '0;
      bus.timeout <= 1'b0;
      shift <= '0;
      hunt <= '0;
      remaining <= '0;
      bit_counter <= 3'd7;
    end else begin
      if (bus.sclk_posedge) bit_counter <= bit_counter - 3'd1;
      case (state)
        IDLE: if (bus.en) begin
          bus.timeout <= 1'b0;
          hunt <= '0;
          remaining <= RW'(DATA_BITS);
          state <= bus.wait_start ? HUNT : SYNC;
        end
        HUNT: if (bus.sclk_posedge) begin
          if (!bus.in) begin
            shift <= shift_next;
            remaining <= RW'(DATA_BITS - 1);
            state <= RECEIVE;
          end else if (hunt == HW'(TIMEOUT_BITS - 1)) begin
            bus.timeout <= 1'b1;
            bus.data <= '1;
            state <= IDLE;
          end else hunt <= hunt + 1'b1;
        end
        SYNC: if (bus.sclk_posedge && bit_counter == 3'd7) begin
          shift <= shift_next;
          remaining <= RW'(DATA_BITS - 1);
          state <= RECEIVE;
        end
        RECEIVE: if (bus.sclk_posedge) begin
          shift <= shift_next;
          remaining <= remaining - 1'b1;
          if (remaining == RW'(1)) begin
            bus.data <= shift_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
